// File: rtl/rom_upload_server.sv
// Host upload path: fetches bytes back out of the loaded ROM regions on ioctl read strobes.
// Optional feature macro: UPLOAD_CHECKSUM_EN adds a 16-bit running sum output (upload_sum).
module rom_upload_server #(
  parameter int          RD_LATENCY = 1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF,
  parameter logic [24:0] TOP_ADDR   = 25'h1C100
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [14:0] mem_addr,
  output logic [4:0]  mem_sel,
  output logic        mem_rd,
  input  logic [7:0]  mem_q,
  output logic [24:0] upload_count,
  output logic        upload_done,
  output logic        overrun
`ifdef UPLOAD_CHECKSUM_EN
  ,
  output logic [15:0] upload_sum
`endif
);

  // state   | meaning
  // IDLE    | no fetch in flight
  // ISSUE   | mem_rd strobe cycle, address/select registered
  // WAIT    | counting RD_LATENCY cycles for mem_q
  // CAPTURE | new ioctl_din visible, byte counted
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

  state_t      r_state, w_next;
  logic [1:0]  r_cnt;
  logic        r_pend_v, w_pend_v;
  logic [24:0] r_pend_addr, w_pend_addr;
  logic        r_unmapped;
  logic        r_upl;
  logic        w_rd_ok, w_take_new, w_use_pend, w_issue, w_cap, w_ovr_set, w_wait;
  logic [24:0] w_req_addr, w_base;
  logic [4:0]  w_sel;
  logic        w_unm;
  logic [14:0] w_local;

  assign w_rd_ok    = ioctl_rd & ioctl_upload;
  assign w_issue    = w_take_new | w_use_pend;
  assign w_req_addr = w_use_pend ? r_pend_addr : ioctl_addr;

  always_comb begin
    w_sel  = 5'b00000;
    w_base = 25'h0;
    w_unm  = 1'b0;
    if (w_req_addr < 25'h08000) begin
      w_sel = 5'b00001;
    end else if (w_req_addr < 25'h10000) begin
      w_sel = 5'b00010; w_base = 25'h08000;
    end else if (w_req_addr < 25'h18000) begin
      w_sel = 5'b00100; w_base = 25'h10000;
    end else if (w_req_addr < 25'h1C000) begin
      w_sel = 5'b01000; w_base = 25'h18000;
    end else if (w_req_addr < TOP_ADDR) begin
      w_sel = 5'b10000; w_base = 25'h1C000;
    end else begin
      w_unm = 1'b1;
    end
    w_local = 15'(w_req_addr - w_base);
  end

  always_comb begin
    w_next      = r_state;
    w_take_new  = 1'b0;
    w_use_pend  = 1'b0;
    w_cap       = 1'b0;
    w_ovr_set   = 1'b0;
    w_pend_v    = r_pend_v;
    w_pend_addr = r_pend_addr;
    if (!ioctl_upload) begin
      w_next   = S_IDLE;
      w_pend_v = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend_v) begin
            w_next = S_ISSUE; w_use_pend = 1'b1;
          end else if (w_rd_ok) begin
            w_next = S_ISSUE; w_take_new = 1'b1;
          end
        end
        S_ISSUE: w_next = S_WAIT;
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            w_next = S_CAPTURE; w_cap = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (r_pend_v) begin
            w_next = S_ISSUE; w_use_pend = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
      if (w_use_pend) w_pend_v = 1'b0;
      // A slot freed this cycle can take the new request; otherwise a full slot drops it.
      if (w_rd_ok && !w_take_new) begin
        if (r_pend_v && !w_use_pend) begin
          w_ovr_set = 1'b1;
        end else begin
          w_pend_v    = 1'b1;
          w_pend_addr = ioctl_addr;
        end
      end
    end
    w_wait = (w_next == S_ISSUE) || (w_next == S_WAIT) || w_pend_v;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_pend_v     <= 1'b0;
      r_pend_addr  <= 25'h0;
      r_unmapped   <= 1'b0;
      r_upl        <= 1'b0;
      ioctl_din    <= 8'h00;
      ioctl_wait   <= 1'b0;
      mem_addr     <= 15'h0;
      mem_sel      <= 5'b00000;
      mem_rd       <= 1'b0;
      upload_count <= 25'h0;
      upload_done  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pend_v    <= w_pend_v;
      r_pend_addr <= w_pend_addr;
      r_upl       <= ioctl_upload;
      ioctl_wait  <= w_wait;
      upload_done <= r_upl & ~ioctl_upload;
      mem_rd      <= w_issue & ~w_unm;
      if (w_issue) begin
        mem_addr   <= w_unm ? 15'h0 : w_local;
        mem_sel    <= w_sel;
        r_unmapped <= w_unm;
      end
      if (w_next == S_ISSUE) r_cnt <= LAT_M1;
      else if (r_state == S_WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (w_cap) begin
        ioctl_din    <= r_unmapped ? FILL_BYTE : mem_q;
        upload_count <= upload_count + 25'd1;
      end
      if (ioctl_upload & ~r_upl) begin
        upload_count <= 25'h0;
        overrun      <= 1'b0;
      end else if (w_ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      upload_sum <= 16'h0;
    end else if (ioctl_upload & ~r_upl) begin
      upload_sum <= 16'h0;
    end else if (w_cap) begin
      upload_sum <= upload_sum + {8'h00, (r_unmapped ? FILL_BYTE : mem_q)};
    end
  end
`endif

endmodule

// File: tb/tb_rom_upload_server.sv
// Bench for rom_upload_server: directed requests, scoreboard of expected bytes checked on each completion.
module tb_rom_upload_server;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'h0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [14:0] mem_addr;
  logic [4:0]  mem_sel;
  logic        mem_rd;
  logic [7:0]  mem_q = 8'h00;
  logic [24:0] upload_count;
  logic        upload_done;
  logic        overrun;
`ifdef UPLOAD_CHECKSUM_EN
  logic [15:0] upload_sum;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]  sb[$];
  logic [24:0] prev_count = 25'h0;

  rom_upload_server #(.RD_LATENCY(1), .FILL_BYTE(8'hFF), .TOP_ADDR(25'h1C100)) dut (
    .CLK(CLK), .RESET(RESET), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_rd(mem_rd), .mem_q(mem_q),
    .upload_count(upload_count), .upload_done(upload_done), .overrun(overrun)
`ifdef UPLOAD_CHECKSUM_EN
    , .upload_sum(upload_sum)
`endif
  );

  always #5 CLK = ~CLK;

  // ROM contents: local byte a of region r holds a[7:0]+r; region 2 offset 0x123 holds 0xA5.
  always @(posedge CLK) begin
    if (mem_rd) begin
      case (mem_sel)
        5'b00001: mem_q <= mem_addr[7:0];
        5'b00010: mem_q <= mem_addr[7:0] + 8'd1;
        5'b00100: mem_q <= (mem_addr == 15'h0123) ? 8'hA5 : mem_addr[7:0] + 8'd2;
        5'b01000: mem_q <= mem_addr[7:0] + 8'd3;
        5'b10000: mem_q <= mem_addr[7:0] + 8'd4;
        default:  mem_q <= 8'hEE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every completion (count steps by one) must deliver the next expected byte.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (upload_count == prev_count + 25'd1) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'(ioctl_din), 32'hDEAD);
        end else begin
          chk("sb_din", 32'(ioctl_din), 32'(sb.pop_front()));
        end
      end
    end
    prev_count = upload_count;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_rd(input logic [24:0] a);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    tick();
    ioctl_rd   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!ioctl_wait) break;
      tick();
    end
    chk("wait_idle_timeout", 32'(ioctl_wait), 32'd0);
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_din", 32'(ioctl_din), 0);
    RESET = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();

    // Fetch in flight, then async reset during WAIT
    pulse_rd(25'h00010);
    chk("pre_rst_mem_rd", 32'(mem_rd), 1);
    tick();
    RESET = 1'b1;
    #1;
    chk("rst_all_zero", {ioctl_din, ioctl_wait, mem_addr, mem_sel, mem_rd},  0);
    chk("rst_count", 32'(upload_count), 0);
    chk("rst_done_ovr", {upload_done, overrun}, 0);
    sb.delete();
    tick();
    RESET = 1'b0;
    tick();
    pulse_rd(25'h00010);
    sb.push_back(8'h10);
    chk("r0_mem_rd", 32'(mem_rd), 1);
    chk("r0_sel", 32'(mem_sel), 32'b00001);
    chk("r0_addr", 32'(mem_addr), 32'h0010);
    wait_idle();

    // Region 2 preloaded byte, latency check
    pulse_rd(25'h10123);
    sb.push_back(8'hA5);
    chk("r2_sel", 32'(mem_sel), 32'b00100);
    chk("r2_addr", 32'(mem_addr), 32'h0123);
    chk("r2_wait_t1", 32'(ioctl_wait), 1);
    tick();
    chk("r2_wait_t2", 32'(ioctl_wait), 1);
    chk("r2_rd_once", 32'(mem_rd), 0);
    tick();
    chk("r2_din_t3", 32'(ioctl_din), 32'hA5);
    chk("r2_wait_t3", 32'(ioctl_wait), 0);
    chk("r2_count", 32'(upload_count), 2);
    tick();

    // Top of region 4, then first unmapped address
    pulse_rd(25'h1C0FF);
    sb.push_back(8'h03);
    chk("r4_sel", 32'(mem_sel), 32'b10000);
    chk("r4_addr", 32'(mem_addr), 32'h00FF);
    wait_idle();
    pulse_rd(25'h1C100);
    sb.push_back(8'hFF);
    chk("unm_mem_rd", 32'(mem_rd), 0);
    chk("unm_sel", 32'(mem_sel), 0);
    chk("unm_wait", 32'(ioctl_wait), 1);
    tick(); tick();
    chk("unm_din_t3", 32'(ioctl_din), 32'hFF);
    chk("unm_wait_t3", 32'(ioctl_wait), 0);
    tick();

    // Back-to-back via pending slot
    pulse_rd(25'h08000);
    sb.push_back(8'h01);
    tick();
    pulse_rd(25'h08001);
    sb.push_back(8'h02);
    chk("pend_din1", 32'(ioctl_din), 32'h01);
    chk("pend_wait_t3", 32'(ioctl_wait), 1);
    tick();
    chk("pend_mem_rd", 32'(mem_rd), 1);
    chk("pend_sel", 32'(mem_sel), 32'b00010);
    chk("pend_addr", 32'(mem_addr), 32'h0001);
    chk("pend_wait_t4", 32'(ioctl_wait), 1);
    tick();
    chk("pend_wait_t5", 32'(ioctl_wait), 1);
    tick();
    chk("pend_din2", 32'(ioctl_din), 32'h02);
    chk("pend_wait_t6", 32'(ioctl_wait), 0);
    chk("pend_no_ovr", 32'(overrun), 0);
    tick();

    // Three consecutive requests: third dropped
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h00020; tick();
    ioctl_addr = 25'h00021; tick();
    ioctl_addr = 25'h00022; tick();
    ioctl_rd = 1'b0;
    sb.push_back(8'h20);
    sb.push_back(8'h21);
    wait_idle();
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_count", 32'(upload_count), 8);

    // New session, checksum bytes, then abort mid-WAIT
    ioctl_upload = 1'b0;
    tick(); tick();
    ioctl_upload = 1'b1;
    tick();
    chk("sess_count_clr", 32'(upload_count), 0);
    chk("sess_ovr_clr", 32'(overrun), 0);
    pulse_rd(25'h1C100);
    sb.push_back(8'hFF);
    wait_idle();
    pulse_rd(25'h08001);
    sb.push_back(8'h02);
    wait_idle();
`ifdef UPLOAD_CHECKSUM_EN
    chk("sum", 32'(upload_sum), 32'h0101);
`endif
    pulse_rd(25'h00030);
    tick();
    ioctl_upload = 1'b0;
    tick();
    chk("abort_wait", 32'(ioctl_wait), 0);
    chk("abort_mem_rd", 32'(mem_rd), 0);
    chk("abort_done", 32'(upload_done), 1);
    tick();
    chk("abort_done_pulse", 32'(upload_done), 0);
    chk("abort_din_hold", 32'(ioctl_din), 32'h02);
    chk("abort_count", 32'(upload_count), 2);
`ifdef UPLOAD_CHECKSUM_EN
    chk("sum_frozen", 32'(upload_sum), 32'h0101);
`endif
    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
